// File: rtl/acc_req_arbiter.sv
// acc_req_arbiter: round-robin, grant-locked sharing of one accelerator port
// with an in-order ID FIFO that routes responses back to their issuers.
module acc_req_arbiter #(
  parameter int NumReq         = 2,
  parameter int MaxOutstanding = 4,
  parameter int ReqWidth       = 64,
  parameter int RespWidth      = 64
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumReq-1:0]                     req_valid_i,
  output logic [NumReq-1:0]                     req_ready_o,
  input  logic [NumReq*ReqWidth-1:0]            req_data_i,
  output logic                                  acc_req_valid_o,
  input  logic                                  acc_req_ready_i,
  output logic [ReqWidth-1:0]                   acc_req_o,
  input  logic                                  acc_resp_valid_i,
  output logic                                  acc_resp_ready_o,
  input  logic [RespWidth-1:0]                  acc_resp_i,
  output logic [NumReq-1:0]                     resp_valid_o,
  input  logic [NumReq-1:0]                     resp_ready_i,
  output logic [RespWidth-1:0]                  resp_data_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  spurious_o
);
  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = $clog2(MaxOutstanding+1);
  localparam int PtrW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;

  logic [IdxW-1:0] r_rr_ptr, r_lock_idx, w_grant, w_head;
  logic            r_lock, r_spurious;
  logic [IdxW-1:0] r_fifo [MaxOutstanding];
  logic [PtrW-1:0] r_rd, r_wr;
  logic [CntW-1:0] r_cnt;
  logic            w_full, w_empty, w_push, w_pop;

  function automatic logic [IdxW-1:0] wrap_idx(input int v);
    return IdxW'(v >= NumReq ? v - NumReq : v);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (int'(p) == MaxOutstanding - 1) ? '0 : p + 1'b1;
  endfunction

  // Highest k is visited first so the nearest valid requester from rr_ptr wins.
  always_comb begin
    w_grant = r_rr_ptr;
    for (int k = NumReq - 1; k >= 0; k--)
      if (req_valid_i[wrap_idx(int'(r_rr_ptr) + k)]) w_grant = wrap_idx(int'(r_rr_ptr) + k);
    if (r_lock) w_grant = r_lock_idx;
  end

  assign w_full           = r_cnt == CntW'(MaxOutstanding);
  assign w_empty          = r_cnt == '0;
  assign w_head           = r_fifo[r_rd];
  assign acc_req_valid_o  = !rst_i && |req_valid_i && req_valid_i[w_grant] && !w_full;
  assign acc_req_o        = req_data_i[w_grant*ReqWidth +: ReqWidth];
  assign w_push           = acc_req_valid_o && acc_req_ready_i;
  assign req_ready_o      = w_push ? NumReq'(1) << w_grant : '0;
  assign resp_valid_o     = (!rst_i && acc_resp_valid_i && !w_empty) ? NumReq'(1) << w_head : '0;
  assign acc_resp_ready_o = !rst_i && !w_empty && resp_ready_i[w_head];
  assign w_pop            = acc_resp_valid_i && acc_resp_ready_o;
  assign resp_data_o      = acc_resp_i;
  assign outstanding_o    = rst_i ? '0 : r_cnt;
  assign spurious_o       = !rst_i && r_spurious;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_cnt      <= '0;
      r_spurious <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr] <= w_grant;
        r_wr         <= ptr_inc(r_wr);
        r_rr_ptr     <= wrap_idx(int'(w_grant) + 1);
        r_lock       <= 1'b0;
      end else if (acc_req_valid_o) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_grant;
      end
      if (w_pop) r_rd <= ptr_inc(r_rd);
      r_cnt <= r_cnt + CntW'(w_push) - CntW'(w_pop);
      if (acc_resp_valid_i && w_empty) r_spurious <= 1'b1;
    end
  end
endmodule

// File: tb/tb_acc_req_arbiter.sv
// tb_acc_req_arbiter: directed scenarios plus randomized traffic checked every
// cycle against a queue-based model of the arbiter.
module tb_acc_req_arbiter;
  localparam int N    = 2;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [N*64-1:0] req_data;
  logic          acc_req_valid, acc_req_ready, acc_resp_valid, acc_resp_ready, spurious;
  logic [63:0]   acc_req, acc_resp, resp_data;
  logic [2:0]    outstanding;

  int   tests = 0, fails = 0;
  int   rr = 0, lock_owner = 0;
  bit   locked = 0, spur = 0;
  int   q[$];
  logic [N-1:0] req_hs;
  bit   resp_hs;
  bit   pend [N];
  bit   rpend;

  always #5 clk = ~clk;

  acc_req_arbiter #(.NumReq(N), .MaxOutstanding(MAXO), .ReqWidth(64), .RespWidth(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .acc_req_valid_o(acc_req_valid), .acc_req_ready_i(acc_req_ready), .acc_req_o(acc_req),
    .acc_resp_valid_i(acc_resp_valid), .acc_resp_ready_o(acc_resp_ready), .acc_resp_i(acc_resp),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
    .outstanding_o(outstanding), .spurious_o(spurious)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: settle, compare against the model, advance the model at the edge.
  task automatic step();
    int g, head;
    bit full, emp, e_arv, e_arr;
    logic [N-1:0] e_rdy, e_rv;
    #1;
    g = rr;
    if (locked) g = lock_owner;
    else
      for (int k = 0; k < N; k++)
        if (req_valid[(rr + k) % N]) begin g = (rr + k) % N; break; end
    full  = q.size() == MAXO;
    emp   = q.size() == 0;
    head  = emp ? 0 : q[0];
    e_arv = !rst && req_valid[g] && !full;
    e_rdy = (e_arv && acc_req_ready) ? N'(1 << g) : '0;
    e_rv  = (!rst && acc_resp_valid && !emp) ? N'(1 << head) : '0;
    e_arr = !rst && !emp && resp_ready[head];
    chk("acc_req_valid", acc_req_valid, e_arv);
    chk("req_ready", req_ready, e_rdy);
    if (e_arv) chk("acc_req_data", acc_req, req_data[g*64 +: 64]);
    chk("resp_valid", resp_valid, e_rv);
    chk("acc_resp_ready", acc_resp_ready, e_arr);
    chk("resp_data", resp_data, acc_resp);
    chk("outstanding", outstanding, rst ? 0 : q.size());
    chk("spurious", spurious, !rst && spur);
    req_hs  = e_rdy;
    resp_hs = acc_resp_valid && e_arr;
    if (rst) begin
      q.delete(); rr = 0; locked = 0; lock_owner = 0; spur = 0;
    end else begin
      if (acc_resp_valid && emp) spur = 1;
      if (resp_hs) void'(q.pop_front());
      if (e_rdy != '0) begin q.push_back(g); rr = (g + 1) % N; locked = 0; end
      else if (e_arv) begin locked = 1; lock_owner = g; end
    end
    @(negedge clk);
  endtask

  task automatic renew();
    for (int i = 0; i < N; i++)
      if (req_hs[i]) req_data[i*64 +: 64] = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    rst = 1; req_valid = '0; acc_req_ready = 0; acc_resp_valid = 0; resp_ready = '0;
    step(); step();
    rst = 0;
  endtask

  initial begin
    rst = 1; req_valid = '0; req_data = '0; acc_req_ready = 0;
    acc_resp_valid = 0; acc_resp = '0; resp_ready = '0;
    @(negedge clk);
    do_reset();
    // single request
    req_valid = 2'b01; req_data[63:0] = 64'hA5; acc_req_ready = 1;
    #1;
    chk("single_ready", req_ready, 2'b01);
    chk("single_data", acc_req, 64'hA5);
    step();
    req_valid = '0;
    chk("single_outstanding", outstanding, 1);
    step();
    // round-robin with lock, then fill the FIFO
    do_reset();
    req_valid = 2'b11; req_data = {64'h1111, 64'h2222}; acc_req_ready = 0;
    repeat (3) step();
    acc_req_ready = 1;
    repeat (4) begin step(); renew(); end
    chk("full_outstanding", outstanding, 4);
    chk("full_blocks_req", acc_req_valid, 0);
    acc_resp_valid = 1; acc_resp = 64'h77; resp_ready = 2'b11;
    step(); renew();
    chk("full_push_blocked", outstanding, 3);
    acc_resp_valid = 0;
    step(); renew();
    chk("resume_outstanding", outstanding, 4);
    // response ordering across requesters
    do_reset();
    acc_req_ready = 1;
    req_valid = 2'b10; step();
    req_valid = 2'b01; step();
    req_valid = 2'b00;
    acc_resp_valid = 1; acc_resp = 64'h11; resp_ready = 2'b01;
    step();
    chk("order_stall", acc_resp_ready, 0);
    chk("order_first_owner", resp_valid, 2'b10);
    resp_ready = 2'b11; step();
    acc_resp = 64'h22;
    #1 chk("order_second_owner", resp_valid, 2'b01);
    step();
    acc_resp_valid = 0; step();
    // randomized traffic
    do_reset();
    for (int i = 0; i < N; i++) pend[i] = 0;
    rpend = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1; req_data[i*64 +: 64] = {$urandom, $urandom};
        end
      if (!rpend && q.size() > 0 && $urandom_range(0, 1) == 1) begin
        rpend = 1; acc_resp = {$urandom, $urandom};
      end
      for (int i = 0; i < N; i++) req_valid[i] = pend[i];
      acc_resp_valid = rpend;
      acc_req_ready  = 1'($urandom_range(0, 1));
      resp_ready     = N'($urandom);
      step();
      for (int i = 0; i < N; i++) if (req_hs[i]) pend[i] = 0;
      if (resp_hs) rpend = 0;
    end
    // spurious response on an empty FIFO
    do_reset();
    acc_resp_valid = 1; acc_resp = 64'h99; resp_ready = 2'b11;
    step();
    repeat (10) step();
    chk("spurious_sticky", spurious, 1);
    // reset in the middle of traffic with a locked request
    do_reset();
    acc_req_ready = 1;
    req_valid = 2'b01; step();
    req_valid = 2'b10; step();
    req_valid = 2'b01; step();
    acc_req_ready = 0; req_valid = 2'b10; step();
    rst = 1; step();
    chk("reset_outstanding", outstanding, 0);
    chk("reset_acc_valid", acc_req_valid, 0);
    rst = 0; req_valid = 2'b11; acc_req_ready = 1;
    #1 chk("post_reset_grant", req_ready, 2'b01);
    step();
    req_valid = '0; step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
